led_sequencer: RTL
==================

# led_sequencer

Parametrised LED pattern generator driving the board's general-purpose outputs (e.g. `mkr_gpio[WIDTH-1:0]`) from the main FPGA clock. A programmable prescaler sets the step rate. One of four patterns (shift, bounce, fill, blink) is selected at run time. Per-step and per-period pulses let other logic synchronise to the display.

## Interface
Parameters:
- `WIDTH`, 8: number of LED outputs; legal range 2..32.
- `DELAY_W`, 25: width of the prescaler counter and `delay` input.
- `DEFAULT_DELAY`, 24000000: prescaler terminal value loaded at reset; must fit in `DELAY_W` bits.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when high, the prescaler runs and the pattern advances; when low, everything freezes.
- `load` in 1: single-cycle strobe; latches `mode`/`delay` and restarts the pattern.
- `mode` in 2: 0 SHIFT, 1 BOUNCE, 2 FILL, 3 BLINK; sampled only on `load`.
- `delay` in DELAY_W: prescaler terminal value; sampled only on `load`.
- `leds` out WIDTH: registered LED pattern.
- `step` out 1: one-cycle pulse, coincident with each `leds` update caused by a tick.
- `wrap` out 1: one-cycle pulse, asserted with `step` when the new pattern equals the mode's initial pattern.

## Operation
- Registers: `cnt` (DELAY_W bits), `delay_r`, `mode_r`, `dir` (BOUNCE direction, 0 = up toward MSB), and `leds`.
- Reset values:
  - `cnt`=0, `delay_r`=DEFAULT_DELAY, `mode_r`=SHIFT, `dir`=0.
  - `leds`=1 (bit 0 set).
  - `step`=0, `wrap`=0.
- Tick: when `enable`=1 and `cnt`==`delay_r`, set `cnt`<=0 and advance the pattern. Otherwise, when `enable`=1, `cnt`<=`cnt`+1. When `enable`=0, `cnt` holds.
- Step period is `delay_r`+1 cycles. `delay_r`=0 gives a step every cycle.
- Initial pattern: 1 for SHIFT, BOUNCE and FILL; all-ones for BLINK.
- Advance rules:
  - SHIFT: rotate left by one; MSB returns to bit 0. Period is WIDTH steps.
  - BOUNCE: one-hot. With `dir`=0, shift left; on reaching the MSB, set `dir`<=1. With `dir`=1, shift right; on reaching bit 0, set `dir`<=0. Each end bit is shown once per pass. Period is 2*WIDTH-2 steps.
  - FILL: `leds`<=(`leds`<<1)|1. From all-ones the next value is 1. Period is WIDTH steps.
  - BLINK: `leds`<=~`leds` (all-ones and all-zeros alternate). Period is 2 steps.
- `load`: in the cycle it is sampled, set `mode_r`<=`mode`, `delay_r`<=`delay`, `cnt`<=0, `dir`<=0, `leds`<=initial pattern of the new mode; `step`/`wrap` are 0.
- `load` takes priority over a coincident tick, and it is honoured even when `enable`=0.
- `wrap` is computed from the next-state pattern, so it fires exactly once per pattern period.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- `load` sampled at edge k: `leds` shows the initial pattern after edge k. With `enable` held high, the first tick update appears after edge k+`delay`+1.
- `step`/`wrap` are high for exactly the one cycle following the tick edge, aligned with the new `leds` value.
- `enable` low for N cycles stretches the current step by exactly N cycles, because `cnt` holds its value rather than clearing.
- Reset assertion mid-operation forces reset values immediately (asynchronous). The first tick after release occurs DEFAULT_DELAY+1 enabled cycles later.
- Changing `mode`/`delay` without `load` has no effect.
- Counter arithmetic is unsigned DELAY_W-bit. `cnt` never exceeds `delay_r`, so no wrap-around occurs.

## Test plan
- SHIFT: WIDTH=8; reset, then `load` with `mode`=0, `delay`=3, `enable`=1.
  - `leds` sequence: 01,02,04,…,80,01.
  - Each value is held 4 cycles.
  - `wrap` pulses only on the 80->01 step.
- BOUNCE: `load` with `mode`=1, `delay`=0.
  - `leds` sequence: 01,02,…,80,40,…,02,01, changing every cycle.
  - `wrap` fires every 14 steps; 80 and 01 each appear once per pass.
- FILL and BLINK: both with `delay`=0.
  - FILL gives 01,03,07,0F,1F,3F,7F,FF,01, with `wrap` on the FF->01 step.
  - BLINK gives FF,00,FF, with `wrap` on every 00->FF step.
- Enable freeze: `delay`=9; drop `enable` for 5 cycles when `cnt`=4.
  - That step lasts 15 cycles.
  - `leds` is stable and `step`=0 throughout the freeze.
- Load/reset mid-run:
  - `load` on the same cycle as a tick gives the initial pattern with `step`=0.
  - `load` while `enable`=0 still updates `leds`.
  - Asserting `reset_n` low mid-step gives `leds`=01, `step`=`wrap`=0 before the next clock edge.
- WIDTH=2 BOUNCE with `delay`=0: `leds` sequence 01,10,01, with `wrap` every 2 steps.

Source files
------------

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : led_sequencer
//  Purpose  : Parametrised LED pattern generator. A programmable prescaler
//             sets the step rate; one of four patterns (SHIFT, BOUNCE, FILL,
//             BLINK) is selected at run time. Per-step and per-period pulses
//             let other logic synchronise to the display.
//  Ports    : clk      - single clock, rising edge
//             reset_n  - asynchronous active-low reset
//             enable   - prescaler runs / pattern advances when high
//             load     - one-cycle strobe: latch mode/delay, restart pattern
//             mode     - 0 SHIFT, 1 BOUNCE, 2 FILL, 3 BLINK (sampled on load)
//             delay    - prescaler terminal value (sampled on load)
//             leds     - registered LED pattern
//             step     - one-cycle pulse with each tick-driven leds update
//             wrap     - pulse with step when the pattern returns to its start
//  Revision : 1.0 - initial release
// ============================================================================
module led_sequencer #(
    parameter int WIDTH         = 8,
    parameter int DELAY_W       = 25,
    parameter int DEFAULT_DELAY = 24000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               load,
    input  logic [1:0]         mode,
    input  logic [DELAY_W-1:0] delay,
    output logic [WIDTH-1:0]   leds,
    output logic               step,
    output logic               wrap
);

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam logic [WIDTH-1:0]   C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   C_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [DELAY_W-1:0] C_DEF_DLY  = DELAY_W'(DEFAULT_DELAY);

    logic [DELAY_W-1:0] cnt_q,   cnt_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    mode_e              mode_q,  mode_d;
    logic               dir_q,   dir_d;
    logic [WIDTH-1:0]   leds_q,  leds_d;
    logic               step_q,  step_d;
    logic               wrap_q,  wrap_d;

    logic               tick;
    logic [WIDTH-1:0]   adv_leds;
    logic               adv_dir;
    logic [WIDTH-1:0]   init_cur;
    logic [WIDTH-1:0]   init_new;

    function automatic logic [WIDTH-1:0] init_pattern(input mode_e m);
        return (m == MODE_BLINK) ? C_ALL_ONES : C_ONE;
    endfunction

    assign init_cur = init_pattern(mode_q);
    assign init_new = init_pattern(mode_e'(mode));
    assign tick     = enable && (cnt_q == delay_q);

    // Next pattern value should a tick occur this cycle.
    always_comb begin
        adv_leds = leds_q;
        adv_dir  = dir_q;
        case (mode_q)
            MODE_SHIFT: adv_leds = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
            MODE_BOUNCE: begin
                // Direction flips on arrival at an end so each end bit is
                // shown exactly once per pass.
                if (!dir_q) begin
                    adv_leds = leds_q << 1;
                    if (adv_leds[WIDTH-1]) adv_dir = 1'b1;
                end else begin
                    adv_leds = leds_q >> 1;
                    if (adv_leds[0]) adv_dir = 1'b0;
                end
            end
            MODE_FILL:  adv_leds = (&leds_q) ? C_ONE : ((leds_q << 1) | C_ONE);
            MODE_BLINK: adv_leds = ~leds_q;
            default:    adv_leds = leds_q;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        delay_d = delay_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        leds_d  = leds_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (load) begin
            // Load wins over a coincident tick and ignores enable.
            mode_d  = mode_e'(mode);
            delay_d = delay;
            cnt_d   = '0;
            dir_d   = 1'b0;
            leds_d  = init_new;
        end else if (enable) begin
            if (tick) begin
                cnt_d  = '0;
                leds_d = adv_leds;
                dir_d  = adv_dir;
                step_d = 1'b1;
                wrap_d = (adv_leds == init_cur);
            end else begin
                cnt_d  = cnt_q + DELAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            delay_q <= C_DEF_DLY;
            mode_q  <= MODE_SHIFT;
            dir_q   <= 1'b0;
            leds_q  <= C_ONE;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            delay_q <= delay_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            leds_q  <= leds_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign leds = leds_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule
`default_nettype wire
